ppe_stm_access_ctrl: RTL
========================

Name: ppe_stm_access_ctrl

Overview:
- Parametrised PPE-side access controller for a shared table memory.
- One buffered write port plus NUM_EM independent exact-match (EM) read ports, with per-chunk enables.
- Registered, fixed-latency memory-side signalling, and same-cycle write-to-read forwarding so a read never returns stale data for a write issued in the same cycle.
- Sits between the RX PPE lookup/update logic and the STM macro wrapper. Successor to the fixed 2-EM, 4-chunk, 17-bit-address link.

Parameters:
- NUM_EM, 2, number of EM read ports.
- NUM_CHUNK, 4, chunks per table row.
- CHUNK_W, 72, bits per chunk, ECC included.
- ADDR_W, 17, row address width.
- RD_LAT, 2, memory read latency in cycles, from tbl_ren to tbl_em_rdata; range 1..4.
- WQ_DEPTH, 4, write queue entries; power of 2, at least 2.

Ports:
- cclk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wr_req_valid  in  1  write request
- wr_req_ready  out  1  write queue can accept
- wr_req_addr  in  ADDR_W  write row address
- wr_req_chunk_en  in  NUM_CHUNK  per-chunk write enables
- wr_req_data  in  NUM_CHUNK*CHUNK_W  write data
- tbl_wr_hold  in  1  stall write drain (scrub/maintenance)
- em_req_valid  in  NUM_EM  per-port read request
- em_req_addr  in  NUM_EM*ADDR_W  per-port read address
- em_req_chunk_en  in  NUM_EM*NUM_CHUNK  per-port chunk read enables
- em_rsp_valid  out  NUM_EM  per-port response valid
- em_rsp_data  out  NUM_EM*NUM_CHUNK*CHUNK_W  per-port response data
- tbl_wen  out  NUM_CHUNK  memory per-chunk write enables
- tbl_ren  out  NUM_EM*NUM_CHUNK  memory per-port, per-chunk read enables
- tbl_addr  out  (NUM_EM+1)*ADDR_W  slot 0 is the write address; slot 1+i is EM port i
- tbl_wdata  out  NUM_CHUNK*CHUNK_W  memory write data
- tbl_em_rdata  in  NUM_EM*NUM_CHUNK*CHUNK_W  memory EM read data
- wq_level  out  $clog2(WQ_DEPTH)+1  write queue occupancy
- fwd_cnt  out  16  saturating count of forwarding events

Behaviour:
- Reset: all outputs are 0. The queue is emptied and every pipeline valid is cleared; in-flight reads are dropped and produce no em_rsp_valid. wr_req_ready rises 1 cycle after reset deasserts.
- Write queue is a FIFO. wr_req_ready = !full, registered. A push happens when valid && ready.
- Write drain: each cycle, if the queue is non-empty and tbl_wr_hold=0, pop the head and drive tbl_wen/tbl_addr[0]/tbl_wdata on the next cycle. Otherwise tbl_wen=0 and tbl_addr[0]/tbl_wdata hold their previous values.
- Queue timing: minimum push-to-tbl_wen latency is 2 cycles. Push and pop in the same cycle leave the level unchanged. Empty and hold produce no memory write.
- A write with chunk_en=0 is accepted, occupies an entry, and issues with tbl_wen=0. It never forwards.
- Read issue: em_req at cycle t drives tbl_ren/tbl_addr[1+i] at t+1 (registered). tbl_ren for port i is em_req_valid[i] & chunk_en.
- Read data: the memory returns data at t+1+RD_LAT. em_rsp_valid/em_rsp_data are registered at t+2+RD_LAT. Total latency is RD_LAT+2, with one response per request and in order per port.
- Unrequested chunks read back as 0. A request with chunk_en=0 still produces em_rsp_valid with all-zero data.
- Memory semantics: the macro is read-first. Writes issued in a cycle before the read's tbl_ren cycle are visible from memory. Writes still queued at read issue are not visible; this is required and documented.
- Forwarding, issue cycle: when tbl_wen != 0 and tbl_addr[0] == tbl_addr[1+i] in the same cycle, capture fwd_mask = tbl_wen & tbl_ren[i] and the tbl_wdata chunks. Carry them down a RD_LAT-deep per-port shift pipeline.
- Forwarding, return: at data return, each chunk with its fwd_mask bit set takes the forwarded data; the other requested chunks take tbl_em_rdata.
- Forwarding counter: fwd_cnt increments by 1 per cycle in which any port has a non-zero fwd_mask at issue. Multiple ports in one cycle still count 1. The counter saturates at 0xFFFF.
- Back-to-back reads on every port every cycle are supported with no bubbles.
- Reset asserted mid-operation clears state asynchronously. The queue does not drain after release.

Test Plan:
- Reset, then 1 write (addr 0x00010, en 4'b1111, data D0) with hold=0: tbl_wen=4'hF 2 cycles after push, tbl_addr[0]=0x00010, wq_level returns to 0.
- Hold=1 and push 5 writes: 4 accepted, wr_req_ready=0, wq_level=4. Release hold: writes drain 1 per cycle in push order.
- EM0 reads addr 0x00020 with en 4'b0101, memory returns pattern P: em_rsp_valid[0] RD_LAT+2 cycles later, chunks 0 and 2 = P, chunks 1 and 3 = 0.
- Write addr 0x00030 (en 4'b0011, data W) issued in the same cycle as an EM1 read of 0x00030 (en 4'b1111), memory returns old O: response chunks 0-1 = W, chunks 2-3 = O, fwd_cnt=1.
- Both ports issue reads every cycle for 20 cycles: 20 responses per port, in order, no gaps.
- Assert rst with 2 reads in flight and 3 queued writes: no em_rsp_valid and no tbl_wen after release, wq_level=0, all outputs 0.

Source files
------------

// File: rtl/ppe_stm_access_ctrl.sv
// PPE-side access controller for the shared table memory: a buffered write port,
// NUM_EM exact-match read ports and same-cycle write-to-read forwarding.
module ppe_stm_access_ctrl #(
    parameter int NUM_EM    = 2,
    parameter int NUM_CHUNK = 4,
    parameter int CHUNK_W   = 72,
    parameter int ADDR_W    = 17,
    parameter int RD_LAT    = 2,
    parameter int WQ_DEPTH  = 4
) (
    input  logic                                cclk,
    input  logic                                rst,
    input  logic                                wr_req_valid,
    output logic                                wr_req_ready,
    input  logic [ADDR_W-1:0]                   wr_req_addr,
    input  logic [NUM_CHUNK-1:0]                wr_req_chunk_en,
    input  logic [NUM_CHUNK*CHUNK_W-1:0]        wr_req_data,
    input  logic                                tbl_wr_hold,
    input  logic [NUM_EM-1:0]                   em_req_valid,
    input  logic [NUM_EM*ADDR_W-1:0]            em_req_addr,
    input  logic [NUM_EM*NUM_CHUNK-1:0]         em_req_chunk_en,
    output logic [NUM_EM-1:0]                   em_rsp_valid,
    output logic [NUM_EM*NUM_CHUNK*CHUNK_W-1:0] em_rsp_data,
    output logic [NUM_CHUNK-1:0]                tbl_wen,
    output logic [NUM_EM*NUM_CHUNK-1:0]         tbl_ren,
    output logic [(NUM_EM+1)*ADDR_W-1:0]        tbl_addr,
    output logic [NUM_CHUNK*CHUNK_W-1:0]        tbl_wdata,
    input  logic [NUM_EM*NUM_CHUNK*CHUNK_W-1:0] tbl_em_rdata,
    output logic [$clog2(WQ_DEPTH):0]           wq_level,
    output logic [15:0]                         fwd_cnt
);
    localparam int ROW_W = NUM_CHUNK * CHUNK_W;
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [NUM_CHUNK-1:0] en;
        logic [ROW_W-1:0]     data;
    } wq_entry_t;

    typedef struct packed {
        logic                 vld;
        logic [NUM_CHUNK-1:0] ren;
        logic [NUM_CHUNK-1:0] fwd;
        logic [ROW_W-1:0]     fdata;
    } rd_stage_t;

    wq_entry_t         wq_mem [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              push;
    logic              pop;

    logic [ADDR_W-1:0]    wr_addr_q;
    logic [ADDR_W-1:0]    rd_addr_q [NUM_EM];
    logic [NUM_EM-1:0]    iss_valid;
    logic [NUM_CHUNK-1:0] fwd_mask [NUM_EM];
    logic                 any_fwd;
    rd_stage_t            pipe [RD_LAT][NUM_EM];

    assign push = wr_req_valid && wr_req_ready;
    assign pop  = (wq_level != '0) && !tbl_wr_hold;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        level_next = wq_level;
        if (push && !pop)
            level_next = wq_level + LVL_W'(1);
        else if (pop && !push)
            level_next = wq_level - LVL_W'(1);
    end

    // NOTE: queue storage carries no reset; the pointers and level alone decide what is valid.
    always_ff @(posedge cclk) begin
        if (push)
            wq_mem[wr_ptr] <= '{addr: wr_req_addr, en: wr_req_chunk_en, data: wr_req_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wq_level     <= '0;
            wr_req_ready <= 1'b0;
            tbl_wen      <= '0;
            wr_addr_q    <= '0;
            tbl_wdata    <= '0;
        end else begin
            wq_level     <= level_next;
            wr_req_ready <= (level_next != LVL_W'(WQ_DEPTH));
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                tbl_wen   <= wq_mem[rd_ptr].en;
                wr_addr_q <= wq_mem[rd_ptr].addr;
                tbl_wdata <= wq_mem[rd_ptr].data;
            end else begin
                tbl_wen <= '0;
            end
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            iss_valid <= '0;
            tbl_ren   <= '0;
            for (int i = 0; i < NUM_EM; i++)
                rd_addr_q[i] <= '0;
        end else begin
            iss_valid <= em_req_valid;
            for (int i = 0; i < NUM_EM; i++) begin
                tbl_ren[i*NUM_CHUNK +: NUM_CHUNK] <=
                    em_req_valid[i] ? em_req_chunk_en[i*NUM_CHUNK +: NUM_CHUNK] : '0;
                if (em_req_valid[i])
                    rd_addr_q[i] <= em_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        tbl_addr = '0;
        tbl_addr[ADDR_W-1:0] = wr_addr_q;
        for (int i = 0; i < NUM_EM; i++)
            tbl_addr[(i+1)*ADDR_W +: ADDR_W] = rd_addr_q[i];
    end

    // The macro is read-first, so a write landing in the read's issue cycle must be forwarded.
    always_comb begin
        any_fwd = 1'b0;
        for (int i = 0; i < NUM_EM; i++) begin
            fwd_mask[i] = (wr_addr_q == rd_addr_q[i]) ?
                          (tbl_wen & tbl_ren[i*NUM_CHUNK +: NUM_CHUNK]) : '0;
            if (fwd_mask[i] != '0)
                any_fwd = 1'b1;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++)
                for (int i = 0; i < NUM_EM; i++)
                    pipe[s][i] <= '0;
            fwd_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_EM; i++) begin
                pipe[0][i].vld   <= iss_valid[i];
                pipe[0][i].ren   <= tbl_ren[i*NUM_CHUNK +: NUM_CHUNK];
                pipe[0][i].fwd   <= fwd_mask[i];
                pipe[0][i].fdata <= tbl_wdata;
                for (int s = 1; s < RD_LAT; s++)
                    pipe[s][i] <= pipe[s-1][i];
            end
            if (any_fwd && fwd_cnt != 16'hFFFF)
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            em_rsp_valid <= '0;
            em_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_EM; i++) begin
                em_rsp_valid[i] <= pipe[RD_LAT-1][i].vld;
                for (int c = 0; c < NUM_CHUNK; c++)
                    em_rsp_data[(i*NUM_CHUNK+c)*CHUNK_W +: CHUNK_W] <=
                        pipe[RD_LAT-1][i].fwd[c] ? pipe[RD_LAT-1][i].fdata[c*CHUNK_W +: CHUNK_W] :
                        pipe[RD_LAT-1][i].ren[c] ? tbl_em_rdata[(i*NUM_CHUNK+c)*CHUNK_W +: CHUNK_W] :
                                                   {CHUNK_W{1'b0}};
            end
        end
    end

endmodule
